sseg_scan_mux: RTL and testbench

Time-multiplexed scanner for the 4-digit common-anode seven-segment display. It holds a 16-bit value and cycles through the digits, one at a time. Each slot drives one nibble on hex into the existing sseg_display decoder and asserts the matching active-low anode. Upstream logic loads values through a strobe. Updates are applied only at frame boundaries, so a displayed value never mixes old and new digits.

---
 rtl/sseg_pkg.sv | 19 +
 rtl/sseg_slot_timer.sv | 43 ++++
 rtl/sseg_scan_mux.sv | 99 +++++++++
 tb/tb_sseg_scan_mux.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/sseg_pkg.sv
// Shared types and helpers for the seven-segment scan path.
package sseg_pkg;

   localparam int unsigned NUM_DIGITS = 4;
   localparam logic [3:0]  ANODES_OFF = 4'b1111;

   typedef logic [1:0] digit_idx_t;
   typedef logic [3:0] nibble_t;

   typedef enum logic {
      ST_ON  = 1'b0,
      ST_GAP = 1'b1
   } slot_state_t;

   function automatic logic [3:0] anode_onehot(input digit_idx_t idx);
      return ~(4'b0001 << idx);
   endfunction

endpackage

// File: rtl/sseg_slot_timer.sv
// Slot counter: marks the start of each digit slot, the anti-ghosting gap,
// and slot starts that follow a completed slot (digit advance).
module sseg_slot_timer #(
   parameter int unsigned DIV          = 10,
   parameter int unsigned BLANK_CYCLES = 2
) (
   input  logic clk_i,
   input  logic rst_i,
   output logic slot_start_o,
   output logic gap_o,
   output logic wrap_o
);

   localparam int unsigned CW = (DIV < 2) ? 1 : $clog2(DIV);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          last;
   logic          wrapped_q;

   assign last         = (cnt_q == CW'(DIV - 1));
   assign slot_start_o = (cnt_q == '0);
   // Compared one bit wider so DIV itself is representable when BLANK_CYCLES=0.
   assign gap_o        = ({1'b0, cnt_q} >= (CW + 1)'(DIV - BLANK_CYCLES));
   assign wrap_o       = slot_start_o && wrapped_q;

   always_comb begin
      cnt_d = cnt_q + CW'(1);
      if (last) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q     <= '0;
         wrapped_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         wrapped_q <= last;
      end
   end

endmodule

// File: rtl/sseg_scan_mux.sv
// Time-multiplexed 4-digit scanner; new values are committed only at frame
// boundaries so a frame never mixes old and new digits.
module sseg_scan_mux
   import sseg_pkg::*;
#(
   parameter int unsigned CLK_HZ       = 100_000_000,
   parameter int unsigned SLOT_HZ      = 1000,
   parameter int unsigned BLANK_CYCLES = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] value,
   input  logic        load,
   input  logic        blank_lz,
   output logic [3:0]  hex,
   output logic [3:0]  an,
   output logic [1:0]  digit_idx,
   output logic        frame_done
);

   localparam int unsigned DIV = CLK_HZ / SLOT_HZ;

   if (DIV < 2) begin : g_div_chk
      $error("sseg_scan_mux: CLK_HZ/SLOT_HZ must be at least 2");
   end
   if (BLANK_CYCLES >= DIV) begin : g_blank_chk
      $error("sseg_scan_mux: BLANK_CYCLES must be less than CLK_HZ/SLOT_HZ");
   end

   logic        slot_start, gap, wrap;
   logic [15:0] pending_q, pending_d;
   logic [15:0] shown_q, shown_d;
   digit_idx_t  dig_q, dig_d;
   nibble_t     hex_q, hex_d;
   logic [3:0]  an_q, an_d;
   logic        fd_q, fd_d;
   logic        boundary, blanked;
   slot_state_t state;

   sseg_slot_timer #(
      .DIV          (DIV),
      .BLANK_CYCLES (BLANK_CYCLES)
   ) u_timer (
      .clk_i        (clk),
      .rst_i        (rst),
      .slot_start_o (slot_start),
      .gap_o        (gap),
      .wrap_o       (wrap)
   );

   always_comb begin
      state     = gap ? ST_GAP : ST_ON;
      pending_d = load ? value : pending_q;
      shown_d   = shown_q;
      dig_d     = dig_q;
      hex_d     = hex_q;
      boundary  = 1'b0;

      if (wrap) begin
         dig_d    = dig_q + digit_idx_t'(1);
         boundary = (dig_q == digit_idx_t'(NUM_DIGITS - 1));
      end
      // A load on the boundary edge bypasses pending so it shows this frame.
      if (boundary) begin
         shown_d = load ? value : pending_q;
      end
      if (slot_start) begin
         hex_d = shown_d[{dig_d, 2'b00} +: 4];
      end

      fd_d    = boundary;
      blanked = blank_lz && (dig_d != '0) && ((shown_d >> {dig_d, 2'b00}) == '0);
      an_d    = (state == ST_GAP || blanked) ? ANODES_OFF : anode_onehot(dig_d);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pending_q <= '0;
         shown_q   <= '0;
         dig_q     <= '0;
         hex_q     <= '0;
         an_q      <= ANODES_OFF;
         fd_q      <= 1'b0;
      end else begin
         pending_q <= pending_d;
         shown_q   <= shown_d;
         dig_q     <= dig_d;
         hex_q     <= hex_d;
         an_q      <= an_d;
         fd_q      <= fd_d;
      end
   end

   assign hex        = hex_q;
   assign an         = an_q;
   assign digit_idx  = dig_q;
   assign frame_done = fd_q;

endmodule

// File: tb/tb_sseg_scan_mux.sv
// Bench for sseg_scan_mux: gap and no-gap builds checked every cycle against a
// time-based model, plus literal expectations at chosen points.
module tb_sseg_scan_mux;

   localparam int DIV = 10;
   localparam int GAP = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] value = '0;
   logic        load = 1'b0;
   logic        blank_lz = 1'b0;

   logic [3:0] hex, an, hex0, an0;
   logic [1:0] digit_idx, digit_idx0;
   logic       frame_done, frame_done0;

   int checks = 0;
   int failures = 0;

   sseg_scan_mux #(
      .CLK_HZ       (1000),
      .SLOT_HZ      (100),
      .BLANK_CYCLES (GAP)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .value      (value),
      .load       (load),
      .blank_lz   (blank_lz),
      .hex        (hex),
      .an         (an),
      .digit_idx  (digit_idx),
      .frame_done (frame_done)
   );

   sseg_scan_mux #(
      .CLK_HZ       (1000),
      .SLOT_HZ      (100),
      .BLANK_CYCLES (0)
   ) dut0 (
      .clk        (clk),
      .rst        (rst),
      .value      (value),
      .load       (load),
      .blank_lz   (blank_lz),
      .hex        (hex0),
      .an         (an0),
      .digit_idx  (digit_idx0),
      .frame_done (frame_done0)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at t=%0t: actual=%h expected=%h", name, $time, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Model: edge number since reset release gives slot, position and digit.
   int          mk;
   int          pos, slot, d;
   logic        bnd, blk;
   logic [15:0] m_pend, m_shown, tmp;
   logic [3:0]  e_an, e_an0, e_hex;
   logic [1:0]  e_dig;
   logic        e_fd;

   initial begin
      forever begin
         @(posedge clk or posedge rst);
         if (rst) begin
            mk = 0; m_pend = '0; m_shown = '0;
            e_an = 4'hF; e_an0 = 4'hF; e_hex = '0; e_dig = '0; e_fd = 1'b0;
         end else begin
            pos  = mk % DIV;
            slot = mk / DIV;
            d    = slot % 4;
            bnd  = (pos == 0) && (d == 0) && (mk > 0);
            if (bnd) m_shown = load ? value : m_pend;
            if (load) m_pend = value;
            tmp   = m_shown >> (4 * d);
            e_hex = tmp[3:0];
            e_dig = 2'(d);
            e_fd  = bnd;
            blk   = blank_lz && (d != 0) && (tmp == 16'h0);
            e_an0 = blk ? 4'hF : ~(4'b0001 << d);
            e_an  = (pos >= DIV - GAP) ? 4'hF : e_an0;
            mk++;
         end
         #1;
         check("an", 16'(an), 16'(e_an));
         check("hex", 16'(hex), 16'(e_hex));
         check("digit_idx", 16'(digit_idx), 16'(e_dig));
         check("frame_done", 16'(frame_done), 16'(e_fd));
         check("an_nogap", 16'(an0), 16'(e_an0));
         check("hex_nogap", 16'(hex0), 16'(e_hex));
         check("frame_done_nogap", 16'(frame_done0), 16'(e_fd));
      end
   end

   initial begin
      step(3);
      check("rst_an", 16'(an), 16'hF);
      check("rst_hex", 16'(hex), 16'h0);
      check("rst_digit", 16'(digit_idx), 16'h0);
      check("rst_fd", 16'(frame_done), 16'h0);

      // Release reset and load 0x1234; committed at the first boundary (k=40).
      rst = 1'b0; value = 16'h1234; load = 1'b1;
      step(1);                                  // k=0
      load = 1'b0;
      check("k0_an", 16'(an), 16'hE);
      check("k0_hex", 16'(hex), 16'h0);
      check("k0_digit", 16'(digit_idx), 16'h0);
      check("k0_fd", 16'(frame_done), 16'h0);
      step(40);                                 // k=40
      check("k40_fd", 16'(frame_done), 16'h1);
      check("k40_hex", 16'(hex), 16'h4);
      check("k40_an", 16'(an), 16'hE);
      step(8);                                  // k=48 gap
      check("k48_an_gap", 16'(an), 16'hF);
      check("k48_hex_hold", 16'(hex), 16'h4);
      check("k48_an_nogap", 16'(an0), 16'hE);
      step(3);                                  // k=51 digit 1
      check("k51_an", 16'(an), 16'hD);
      check("k51_hex", 16'(hex), 16'h3);
      step(10);                                 // k=61 digit 2
      check("k61_an", 16'(an), 16'hB);
      check("k61_hex", 16'(hex), 16'h2);
      step(10);                                 // k=71 digit 3
      check("k71_an", 16'(an), 16'h7);
      check("k71_hex", 16'(hex), 16'h1);

      // Mid-frame load while digit 1 shows.
      step(20);                                 // k=91
      value = 16'hABCD; load = 1'b1;
      step(1);                                  // k=92
      load = 1'b0;
      step(19);                                 // k=111
      check("k111_hex_old", 16'(hex), 16'h1);
      step(9);                                  // k=120
      check("k120_fd", 16'(frame_done), 16'h1);
      check("k120_hex", 16'(hex), 16'hD);

      // Last load before the boundary wins.
      value = 16'h1111; load = 1'b1;
      step(1);                                  // k=121
      load = 1'b0;
      step(5);
      value = 16'h2222; load = 1'b1;
      step(1);                                  // k=127
      load = 1'b0;
      step(33);                                 // k=160
      check("k160_hex", 16'(hex), 16'h2);
      check("k160_fd", 16'(frame_done), 16'h1);

      // Load on the boundary cycle itself.
      step(39);                                 // k=199
      value = 16'h3333; load = 1'b1;
      step(1);                                  // k=200
      check("k200_hex", 16'(hex), 16'h3);
      check("k200_fd", 16'(frame_done), 16'h1);

      // Leading-zero blanking.
      value = 16'h00A0; blank_lz = 1'b1;
      step(1);                                  // k=201
      load = 1'b0;
      step(39);                                 // k=240
      check("lz_d0_an", 16'(an), 16'hE);
      check("lz_d0_hex", 16'(hex), 16'h0);
      step(10);                                 // k=250
      check("lz_d1_an", 16'(an), 16'hD);
      check("lz_d1_hex", 16'(hex), 16'hA);
      step(10);                                 // k=260
      check("lz_d2_an", 16'(an), 16'hF);
      check("lz_d2_an_nogap", 16'(an0), 16'hF);
      step(10);                                 // k=270
      check("lz_d3_an", 16'(an), 16'hF);
      value = 16'h0000; load = 1'b1;
      step(1);                                  // k=271
      load = 1'b0;
      step(9);                                  // k=280
      check("lz0_d0_an", 16'(an), 16'hE);
      check("lz0_d0_hex", 16'(hex), 16'h0);
      step(10);                                 // k=290
      check("lz0_d1_an", 16'(an), 16'hF);

      // Asynchronous reset mid-slot discards pending.
      blank_lz = 1'b0; value = 16'h5678; load = 1'b1;
      step(1);                                  // k=291
      load = 1'b0;
      step(29);                                 // k=320
      check("k320_hex", 16'(hex), 16'h8);
      step(10);                                 // k=330
      value = 16'h9999; load = 1'b1;
      step(1);                                  // k=331
      load = 1'b0;
      step(10);                                 // k=341
      check("k341_an", 16'(an), 16'hB);
      check("k341_hex", 16'(hex), 16'h6);
      #3 rst = 1'b1;
      #1;
      check("arst_an", 16'(an), 16'hF);
      check("arst_hex", 16'(hex), 16'h0);
      check("arst_digit", 16'(digit_idx), 16'h0);
      check("arst_hex_nogap", 16'(hex0), 16'h0);
      @(negedge clk);
      rst = 1'b0;
      step(1);                                  // k=0
      check("rel_an", 16'(an), 16'hE);
      check("rel_hex", 16'(hex), 16'h0);
      check("rel_digit", 16'(digit_idx), 16'h0);
      step(40);                                 // k=40
      check("rel_fd", 16'(frame_done), 16'h1);
      check("rel_hex_discard", 16'(hex), 16'h0);
      step(11);                                 // k=51
      check("rel_d1_hex", 16'(hex), 16'h0);
      check("rel_d1_an", 16'(an), 16'hD);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
